// File: rtl/dpram_burst_reader_if.sv
// ---------------------------------------------------------------------------
// dpram_burst_reader_if
// Bundles every handshake/bus signal of the port-B burst reader:
//   command    : cmdValid, cmdReady, cmdAddr, cmdLen
//   RAM port B : ba, bcs, bwe, bi (engine -> RAM), bo (RAM -> engine)
//   stream     : dout, dvalid, dlast (engine -> consumer), dready
//   status     : busy, done
//   abort      : only present when DPRAM_RD_ABORT_EN is defined
// Modports:
//   master : the burst reader engine itself
//   slave  : the environment (command source, RAM, stream consumer)
// ---------------------------------------------------------------------------
interface dpram_burst_reader_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          cmdValid;
  logic          cmdReady;
  logic [AW-1:0] cmdAddr;
  logic [AW:0]   cmdLen;
  logic [AW-1:0] ba;
  logic          bcs;
  logic          bwe;
  logic [DW-1:0] bi;
  logic [DW-1:0] bo;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          dready;
  logic          dlast;
  logic          busy;
  logic          done;
`ifdef DPRAM_RD_ABORT_EN
  logic          abort;

  modport master (
    input  cmdValid, cmdAddr, cmdLen, bo, dready, abort,
    output cmdReady, ba, bcs, bwe, bi, dout, dvalid, dlast, busy, done
  );

  modport slave (
    output cmdValid, cmdAddr, cmdLen, bo, dready, abort,
    input  cmdReady, ba, bcs, bwe, bi, dout, dvalid, dlast, busy, done
  );
`else
  modport master (
    input  cmdValid, cmdAddr, cmdLen, bo, dready,
    output cmdReady, ba, bcs, bwe, bi, dout, dvalid, dlast, busy, done
  );

  modport slave (
    output cmdValid, cmdAddr, cmdLen, bo, dready,
    input  cmdReady, ba, bcs, bwe, bi, dout, dvalid, dlast, busy, done
  );
`endif
endinterface

// File: rtl/dpram_burst_reader.sv
// ---------------------------------------------------------------------------
// dpram_burst_reader
// Port-B read engine for a 2K x 8 dual-port block RAM. Accepts a start
// address / byte count command, issues sequential synchronous reads on the
// RAM B port and hands the bytes to a consumer as a valid/ready stream
// through a small credit-managed FIFO.
//
// Ports:
//   i_clk    : single clock, also the RAM B-port clock
//   i_rst_n  : asynchronous active-low reset
//   io_bus   : dpram_burst_reader_if.master (command, RAM port B, stream,
//              busy/done status, optional abort)
// Parameters:
//   AW (address width), DW (data width), FIFO_DEPTH (power of two, >= 2)
// Build option:
//   DPRAM_RD_ABORT_EN : when defined, io_bus.abort cancels a running command
//                       (flush, back to IDLE, DONE pulse). Undefined: no abort.
// ---------------------------------------------------------------------------
module dpram_burst_reader #(
  parameter int AW         = 11,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  dpram_burst_reader_if.master io_bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_ba;
  logic [AW:0]   r_issue;
  logic [AW:0]   r_beat;
  logic          r_bcs;
  logic          r_busy;
  logic          r_done;
  logic          r_inflight;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic          w_dvalid;
  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic          w_lastBeat;
  logic          w_abort;
  logic          w_credit;
  logic [CW-1:0] w_countNext;

`ifdef DPRAM_RD_ABORT_EN
  assign w_abort = io_bus.abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_dvalid    = (r_count != '0);
  assign w_pop       = w_dvalid && io_bus.dready;
  assign w_push      = r_inflight;
  assign w_accept    = io_bus.cmdValid && (r_state == IDLE);
  assign w_lastBeat  = w_pop && (r_beat == LEN_ONE);
  assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

  // BCS is registered, so the credit test is evaluated on next-cycle values:
  // next occupancy plus the read issued this cycle (which becomes next
  // cycle's in-flight read) must leave room for one more.
  assign w_credit = ({1'b0, w_countNext} + (CW+1)'(r_bcs)) < DEPTH_W;

  assign io_bus.cmdReady = ~r_busy;
  assign io_bus.ba       = r_ba;
  assign io_bus.bcs      = r_bcs;
  assign io_bus.bwe      = 1'b0;
  assign io_bus.bi       = '0;
  assign io_bus.dvalid   = w_dvalid;
  assign io_bus.dout     = w_dvalid ? r_mem[r_rdPtr] : '0;
  assign io_bus.dlast    = w_dvalid && (r_beat == LEN_ONE);
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;

  // Command FSM: owns the address/issue/beat counters and drives the
  // registered RAM strobes plus busy/done. Abort wins over everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_ba    <= '0;
      r_issue <= '0;
      r_beat  <= '0;
      r_bcs   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_issue <= '0;
        r_beat  <= '0;
        r_bcs   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_bcs <= 1'b0;
            if (w_accept) begin
              if (io_bus.cmdLen == '0) begin
                r_done <= 1'b1;
              end else begin
                // First read goes out straight away; the FIFO is empty here.
                r_ba    <= io_bus.cmdAddr;
                r_addr  <= io_bus.cmdAddr + ADDR_ONE;
                r_issue <= io_bus.cmdLen - LEN_ONE;
                r_beat  <= io_bus.cmdLen;
                r_bcs   <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= RUN;
              end
            end
          end
          RUN: begin
            if (w_pop) begin
              r_beat <= r_beat - LEN_ONE;
            end
            if ((r_issue != '0) && w_credit) begin
              r_bcs   <= 1'b1;
              r_ba    <= r_addr;
              r_addr  <= r_addr + ADDR_ONE;
              r_issue <= r_issue - LEN_ONE;
              if (r_issue == LEN_ONE) begin
                r_state <= DRAIN;
              end
            end else begin
              r_bcs <= 1'b0;
              if (r_issue == '0) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            r_bcs <= 1'b0;
            if (w_pop) begin
              r_beat <= r_beat - LEN_ONE;
            end
            if (w_lastBeat) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_bcs   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO bookkeeping. A read issued in cycle t returns on BO in cycle t+1 and
  // is pushed on the edge closing that cycle; r_inflight marks that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
    end else if (w_abort) begin
      r_inflight <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= r_bcs;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_count <= w_countNext;
    end
  end

  // Storage needs no reset: DOUT is gated by DVALID, and stale entries are
  // never visible because the pointers/count are reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !w_abort) begin
      r_mem[r_wrPtr] <= io_bus.bo;
    end
  end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_dpram_burst_reader
// Directed bench for dpram_burst_reader: a behavioural 2K x 8 RAM on port B,
// a negedge monitor logging reads/beats/done pulses, and a linear sequence of
// directed commands checked with immediate assertions.
// ---------------------------------------------------------------------------
module tb_dpram_burst_reader;

  logic clk = 1'b0;
  logic rstN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;

  logic [7:0] ram [2048];

  int         bcsCycLog[$];
  logic [10:0] baLog[$];
  logic [7:0] beatData[$];
  logic       beatLastQ[$];
  int         beatCyc[$];
  int         doneCyc[$];
  int         doneCount = 0;
  int         issued = 0;
  int         popped = 0;
  int         maxOutstanding = 0;
  int         creditViolations = 0;
  int         holdViolations = 0;
  logic       prevValid = 1'b0;
  logic       prevPop = 1'b0;
  logic [7:0] prevDout = 8'h00;
  logic       abortNow;

  logic [7:0]  exp1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [10:0] expBa2 [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

  int bBcs, bBeat, bDone, n, bad, lastCnt;

  dpram_burst_reader_if #(.AW(11), .DW(8)) bus ();

  dpram_burst_reader #(
    .AW(11),
    .DW(8),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM port B: synchronous read, data the cycle after BCS.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) bus.bo <= 8'h00;
    else if (bus.bcs) bus.bo <= ram[bus.ba];
  end

  // Expected RAM contents: four fixed bytes at 0x010, a hash elsewhere.
  function automatic logic [7:0] ramModel(input int a);
    case (a)
      'h010: return 8'h11;
      'h011: return 8'h22;
      'h012: return 8'h33;
      'h013: return 8'h44;
      default: return 8'(((a * 37) ^ (a >> 3)) + 5);
    endcase
  endfunction

  function automatic logic [7:0] dataAt(input int idx);
    if (idx < beatData.size()) return beatData[idx];
    return 8'hxx;
  endfunction

  function automatic logic lastAt(input int idx);
    if (idx < beatLastQ.size()) return beatLastQ[idx];
    return 1'bx;
  endfunction

  function automatic int beatCycAt(input int idx);
    if (idx < beatCyc.size()) return beatCyc[idx];
    return -1;
  endfunction

  function automatic int bcsCycAt(input int idx);
    if (idx < bcsCycLog.size()) return bcsCycLog[idx];
    return -1;
  endfunction

  function automatic logic [10:0] baAt(input int idx);
    if (idx < baLog.size()) return baLog[idx];
    return 11'hxxx;
  endfunction

  function automatic int doneCycAt(input int idx);
    if (idx < doneCyc.size()) return doneCyc[idx];
    return -1;
  endfunction

  function automatic int lastCount(input int from);
    int c = 0;
    for (int i = from; i < beatLastQ.size(); i++) if (beatLastQ[i]) c++;
    return c;
  endfunction

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    abortNow = 1'b0;
`ifdef DPRAM_RD_ABORT_EN
    abortNow = bus.abort && bus.busy;
`endif
    if (!rstN || abortNow) begin
      issued = 0;
      popped = 0;
      prevValid = 1'b0;
      prevPop = 1'b0;
    end else begin
      if (bus.bcs) begin
        if (issued - popped >= 4) creditViolations++;
        bcsCycLog.push_back(cyc);
        baLog.push_back(bus.ba);
        issued++;
        if (issued - popped > maxOutstanding) maxOutstanding = issued - popped;
      end
      if (prevValid && !prevPop && (!bus.dvalid || bus.dout !== prevDout)) holdViolations++;
      if (bus.dvalid && bus.dready) begin
        beatData.push_back(bus.dout);
        beatLastQ.push_back(bus.dlast);
        beatCyc.push_back(cyc);
        popped++;
      end
      prevValid = bus.dvalid;
      prevPop = bus.dvalid && bus.dready;
      prevDout = bus.dout;
    end
    if (rstN && bus.done) begin
      doneCount++;
      doneCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] addr, input logic [11:0] len);
    @(posedge clk); #1;
    bus.cmdValid = 1'b1;
    bus.cmdAddr = addr;
    bus.cmdLen = len;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0;
    acceptCyc = cyc;
  endtask

  task automatic waitDone(input int baseDone, input int budget);
    int k = 0;
    while (doneCount == baseDone && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic waitBeats(input int baseBeat, input int want, input int budget);
    int k = 0;
    while (beatData.size() - baseBeat < want && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_cmdReady"}, bus.cmdReady, 1);
    checkOutput({pfx, "_ba"}, bus.ba, 0);
    checkOutput({pfx, "_bcs"}, bus.bcs, 0);
    checkOutput({pfx, "_bwe"}, bus.bwe, 0);
    checkOutput({pfx, "_bi"}, bus.bi, 0);
    checkOutput({pfx, "_dout"}, bus.dout, 0);
    checkOutput({pfx, "_dvalid"}, bus.dvalid, 0);
    checkOutput({pfx, "_dlast"}, bus.dlast, 0);
    checkOutput({pfx, "_busy"}, bus.busy, 0);
    checkOutput({pfx, "_done"}, bus.done, 0);
  endtask

  task automatic checkTwoBeatRun(input string pfx, input logic [10:0] addr);
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(addr, 12'd2);
    waitDone(bDone, 50);
    checkOutput({pfx, "_done"}, doneCount - bDone, 1);
    checkOutput({pfx, "_beats"}, beatData.size() - bBeat, 2);
    checkOutput({pfx, "_d0"}, dataAt(bBeat), ramModel(int'(addr)));
    checkOutput({pfx, "_d1"}, dataAt(bBeat + 1), ramModel(int'(addr) + 1));
    checkOutput({pfx, "_last0"}, lastAt(bBeat), 0);
    checkOutput({pfx, "_last1"}, lastAt(bBeat + 1), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = ramModel(a);
    rstN = 1'b0;
    bus.cmdValid = 1'b0;
    bus.cmdAddr = '0;
    bus.cmdLen = '0;
    bus.dready = 1'b1;
`ifdef DPRAM_RD_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk) rstN = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 4-byte burst with DREADY held high.
    $display("[TB] basic burst addr 0x010 len 4");
    bBcs = bcsCycLog.size();
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h010, 12'd4);
    waitDone(bDone, 100);
    checkOutput("t1_done", doneCount - bDone, 1);
    checkOutput("t1_bcsCount", bcsCycLog.size() - bBcs, 4);
    checkOutput("t1_bcsFirstCyc", bcsCycAt(bBcs) - acceptCyc, 0);
    checkOutput("t1_bcsLastCyc", bcsCycAt(bBcs + 3) - acceptCyc, 3);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_data%0d", i), dataAt(bBeat + i), exp1[i]);
      checkOutput($sformatf("t1_cyc%0d", i), beatCycAt(bBeat + i) - acceptCyc, 2 + i);
      checkOutput($sformatf("t1_last%0d", i), lastAt(bBeat + i), (i == 3) ? 1 : 0);
    end
    checkOutput("t1_doneCyc", doneCycAt(bDone) - acceptCyc, 6);

    // Address wrap 0x7FF -> 0x000.
    $display("[TB] wrap burst addr 0x7FE len 4");
    bBcs = bcsCycLog.size();
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h7FE, 12'd4);
    waitDone(bDone, 100);
    checkOutput("t2_done", doneCount - bDone, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_ba%0d", i), baAt(bBcs + i), expBa2[i]);
      checkOutput($sformatf("t2_data%0d", i), dataAt(bBeat + i), ramModel(int'(expBa2[i])));
    end

    // Zero-length command: DONE only.
    $display("[TB] zero length command");
    bBcs = bcsCycLog.size();
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h100, 12'd0);
    checkOutput("t3_donePulse", bus.done, 1);
    checkOutput("t3_cmdReady", bus.cmdReady, 1);
    checkOutput("t3_busy", bus.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_doneCount", doneCount - bDone, 1);
    checkOutput("t3_noBcs", bcsCycLog.size() - bBcs, 0);
    checkOutput("t3_noBeat", beatData.size() - bBeat, 0);

    // Single-byte command.
    $display("[TB] single byte command");
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h3A5, 12'd1);
    waitDone(bDone, 50);
    checkOutput("t4_done", doneCount - bDone, 1);
    checkOutput("t4_beats", beatData.size() - bBeat, 1);
    checkOutput("t4_data", dataAt(bBeat), ramModel('h3A5));
    checkOutput("t4_last", lastAt(bBeat), 1);

    // Consumer stalled for 10 cycles: credit limits reads to the FIFO depth.
    $display("[TB] stalled consumer len 8");
    bBcs = bcsCycLog.size();
    bBeat = beatData.size();
    bDone = doneCount;
    bus.dready = 1'b0;
    applyStimulus(11'h020, 12'd8);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_bcsWhileStalled", bcsCycLog.size() - bBcs, 4);
    checkOutput("t5_dvalidHeld", bus.dvalid, 1);
    checkOutput("t5_doutHeld", bus.dout, ramModel('h020));
    checkOutput("t5_noBeat", beatData.size() - bBeat, 0);
    bus.dready = 1'b1;
    waitDone(bDone, 100);
    checkOutput("t5_done", doneCount - bDone, 1);
    checkOutput("t5_beats", beatData.size() - bBeat, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (dataAt(bBeat + i) !== ramModel('h020 + i)) bad++;
    checkOutput("t5_dataOrder", bad, 0);
    checkOutput("t5_lastCount", lastCount(bBeat), 1);
    checkOutput("t5_lastOnFinal", lastAt(bBeat + 7), 1);

    // Full 2048-byte command with a random consumer.
    $display("[TB] full 2048 byte command, random DREADY");
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h123, 12'd2048);
    n = 0;
    while (doneCount == bDone && n < 20000) begin
      @(posedge clk); #1;
      bus.dready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.dready = 1'b1;
    waitDone(bDone, 20);
    checkOutput("t6_done", doneCount - bDone, 1);
    checkOutput("t6_beats", beatData.size() - bBeat, 2048);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (dataAt(bBeat + i) !== ramModel((('h123 + i) % 2048))) bad++;
    checkOutput("t6_dataOrder", bad, 0);
    lastCnt = lastCount(bBeat);
    checkOutput("t6_lastCount", lastCnt, 1);
    checkOutput("t6_lastOnFinal", lastAt(bBeat + 2047), 1);
    checkOutput("t6_maxOutstandingOk", (maxOutstanding <= 4) ? 1 : 0, 1);
    checkOutput("t6_creditViolations", creditViolations, 0);

    // Reset in the middle of a command, then a clean 2-byte command.
    $display("[TB] reset mid command");
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h200, 12'd8);
    waitBeats(bBeat, 3, 100);
    #3;
    rstN = 1'b0;
    #1;
    checkResetValues("midReset");
    checkOutput("t7_beatsBeforeReset", beatData.size() - bBeat, 3);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (2) @(posedge clk);
    checkOutput("t7_noDone", doneCount - bDone, 0);
    checkTwoBeatRun("t7_after", 11'h050);

`ifdef DPRAM_RD_ABORT_EN
    // Abort in the middle of a command: flush plus DONE pulse.
    $display("[TB] abort mid command");
    bBeat = beatData.size();
    bDone = doneCount;
    applyStimulus(11'h300, 12'd8);
    waitBeats(bBeat, 3, 100);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checkOutput("t8_dvalid", bus.dvalid, 0);
    checkOutput("t8_bcs", bus.bcs, 0);
    checkOutput("t8_busy", bus.busy, 0);
    checkOutput("t8_donePulse", bus.done, 1);
    @(posedge clk); #1;
    checkOutput("t8_doneOneCycle", bus.done, 0);
    checkOutput("t8_beats", beatData.size() - bBeat, 3);
    checkOutput("t8_doneCount", doneCount - bDone, 1);
    checkTwoBeatRun("t8_after", 11'h060);
`endif

    checkOutput("holdViolations", holdViolations, 0);
    checkOutput("creditViolations", creditViolations, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
